// File: rtl/scam_port_arbiter_pkg.sv
// Shared types for the round-robin output-port arbiter: section enum and the
// pointer-width helper used for rr_ptr / grant_id.
package scam_arb_types;

   typedef enum logic {
      section_idle,
      section_send
   } Sections;

   // clog2 clamped to at least one bit so a single-requester build still has a port
   function automatic int ARB_PTR_W(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/scam_port_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping
// at NUM_REQ-1 -> 0. Returns one-hot grant, its index and an any flag.
module scam_rr_picker
   import scam_arb_types::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]               req,
   input  logic [ARB_PTR_W(NUM_REQ)-1:0]    ptr,
   output logic [NUM_REQ-1:0]               grant,
   output logic [ARB_PTR_W(NUM_REQ)-1:0]    idx,
   output logic                             any
);

   localparam int PW = ARB_PTR_W(NUM_REQ);

   logic          found;
   int            c;
   logic [PW-1:0] ci;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      c     = 0;
      ci    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         // ptr is always < NUM_REQ, so one subtraction is enough to wrap
         c = int'(ptr) + k;
         if (c >= NUM_REQ) c = c - NUM_REQ;
         ci = PW'(c);
         if (!found && req[ci]) begin
            found     = 1'b1;
            grant[ci] = 1'b1;
            idx       = ci;
         end
      end
      any = found;
   end

endmodule

// File: rtl/scam_port_arbiter.sv
// Round-robin arbiter sharing one notify/sync output port among NUM_REQ
// producers; the accepted word is registered and replayed until consumed.
module scam_port_arbiter
   import scam_arb_types::*;
#(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 32
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ*DATA_W-1:0]      req_data,
   input  logic [NUM_REQ-1:0]             req_notify,
   output logic [NUM_REQ-1:0]             req_sync,
   output logic signed [DATA_W-1:0]       out_data,
   output logic                           out_notify,
   input  logic                           out_sync,
   output logic [ARB_PTR_W(NUM_REQ)-1:0]  grant_id
);

   localparam int PW = ARB_PTR_W(NUM_REQ);

   Sections                  state, state_nxt;
   logic [PW-1:0]            rr_ptr, rr_ptr_nxt;
   logic signed [DATA_W-1:0] data_nxt;
   logic                     notify_nxt;
   logic [PW-1:0]            gid_nxt;

   logic [NUM_REQ-1:0]       pick_oh;
   logic [PW-1:0]            pick_idx;
   logic                     pick_any;
   logic                     load, accept;

   scam_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
      .req   (req_notify),
      .ptr   (rr_ptr),
      .grant (pick_oh),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   // A slot opens when the port is empty or its word leaves on this edge
   assign load   = (state == section_idle) || out_sync;
   assign accept = load && pick_any;
   assign req_sync = (accept && !rst) ? pick_oh : '0;

   always_comb begin
      state_nxt  = state;
      rr_ptr_nxt = rr_ptr;
      data_nxt   = out_data;
      notify_nxt = out_notify;
      gid_nxt    = grant_id;
      if (accept) begin
         state_nxt  = section_send;
         data_nxt   = req_data[int'(pick_idx)*DATA_W +: DATA_W];
         notify_nxt = 1'b1;
         gid_nxt    = pick_idx;
         rr_ptr_nxt = (int'(pick_idx) == NUM_REQ-1) ? '0 : pick_idx + PW'(1);
      end else if (load) begin
         state_nxt  = section_idle;
         notify_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= section_idle;
         rr_ptr     <= '0;
         out_data   <= '0;
         out_notify <= 1'b0;
         grant_id   <= '0;
      end else begin
         state      <= state_nxt;
         rr_ptr     <= rr_ptr_nxt;
         out_data   <= data_nxt;
         out_notify <= notify_nxt;
         grant_id   <= gid_nxt;
      end
   end

endmodule

// File: tb/tb_scam_port_arbiter.sv
// Bench for scam_port_arbiter: hand-derived per-cycle vector table plus a
// reference model whose accepted words are queued and checked on delivery.
module tb_scam_port_arbiter;

   localparam int N = 4;
   localparam int W = 32;

   logic                clk = 1'b0;
   logic                rst;
   logic [N*W-1:0]      req_data;
   logic [N-1:0]        req_notify;
   logic [N-1:0]        req_sync;
   logic signed [W-1:0] out_data;
   logic                out_notify;
   logic                out_sync;
   logic [1:0]          grant_id;

   logic signed [W-1:0] rd [N];

   int checks = 0;
   int errors = 0;

   scam_port_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_data   (req_data),
      .req_notify (req_notify),
      .req_sync   (req_sync),
      .out_data   (out_data),
      .out_notify (out_notify),
      .out_sync   (out_sync),
      .grant_id   (grant_id)
   );

   always #5 clk = ~clk;

   always_comb begin
      req_data = '0;
      for (int i = 0; i < N; i++) req_data[i*W +: W] = rd[i];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- scoreboard: independent model of accept/deliver ----------
   typedef struct {
      logic signed [W-1:0] data;
      logic [1:0]          id;
   } word_t;

   word_t    sb_q[$];
   logic [1:0] m_ptr = '0;

   always @(negedge clk) begin
      logic [N-1:0] exp_sync;
      logic         m_load;
      int           w;
      if (rst) begin
         sb_q.delete();
         m_ptr = '0;
         chk("sb_rst_sync", {28'd0, req_sync}, 32'd0);
      end else begin
         m_load = (sb_q.size() == 0) || out_sync;
         chk("sb_notify", {31'd0, out_notify}, {31'd0, sb_q.size() != 0});
         if (sb_q.size() != 0) begin
            chk("sb_data", out_data, sb_q[0].data);
            chk("sb_gid", {30'd0, grant_id}, {30'd0, sb_q[0].id});
         end
         w = -1;
         for (int k = 0; k < N; k++)
            if (w < 0 && req_notify[(int'(m_ptr) + k) % N]) w = (int'(m_ptr) + k) % N;
         exp_sync = '0;
         if (m_load && w >= 0) exp_sync[w] = 1'b1;
         chk("sb_sync", {28'd0, req_sync}, {28'd0, exp_sync});
         if (sb_q.size() != 0 && out_sync) void'(sb_q.pop_front());
         if (m_load && w >= 0) begin
            sb_q.push_back('{data: rd[w], id: 2'(w)});
            m_ptr = 2'((w + 1) % N);
         end
      end
   end

   // ---------------- vector table ---------------------------------------------
   typedef struct {
      logic [N-1:0] notify;
      logic         osync;
      logic [N-1:0] e_sync;
      logic         e_onot;
      logic [1:0]   e_gid;
   } vec_t;

   vec_t vt[$];

   task automatic add(input logic [N-1:0] n, input logic s, input logic [N-1:0] es,
                      input logic eo, input logic [1:0] eg);
      vt.push_back('{notify: n, osync: s, e_sync: es, e_onot: eo, e_gid: eg});
   endtask

   initial begin
      rst = 1'b1; req_notify = '0; out_sync = 1'b0;
      rd[0] = 32'sd100; rd[1] = -32'sd200; rd[2] = -32'sd7; rd[3] = 32'sh7fffffff;

      // round-robin from ptr 0, then drain
      add(4'b1111, 1, 4'b0001, 0, 0);
      add(4'b1111, 1, 4'b0010, 1, 0);
      add(4'b1111, 1, 4'b0100, 1, 1);
      add(4'b1111, 1, 4'b1000, 1, 2);
      add(4'b1111, 1, 4'b0001, 1, 3);
      add(4'b1111, 1, 4'b0010, 1, 0);
      add(4'b0000, 1, 4'b0000, 1, 1);
      add(4'b0000, 0, 4'b0000, 0, 1);
      // single request held five cycles, ptr 2
      add(4'b0100, 0, 4'b0100, 0, 1);
      for (int i = 0; i < 5; i++) add(4'b0000, 0, 4'b0000, 1, 2);
      add(4'b0000, 1, 4'b0000, 1, 2);
      add(4'b0000, 0, 4'b0000, 0, 2);
      // wrap/skip from ptr 3
      add(4'b0011, 1, 4'b0001, 0, 2);
      add(4'b0011, 1, 4'b0010, 1, 0);
      add(4'b0000, 1, 4'b0000, 1, 1);
      add(4'b0000, 0, 4'b0000, 0, 1);
      // backpressure from ptr 2
      add(4'b1111, 0, 4'b0100, 0, 1);
      add(4'b1111, 0, 4'b0000, 1, 2);
      add(4'b1111, 0, 4'b0000, 1, 2);
      add(4'b1111, 0, 4'b0000, 1, 2);
      add(4'b1111, 1, 4'b1000, 1, 2);
      add(4'b1111, 0, 4'b0000, 1, 3);
      add(4'b0000, 1, 4'b0000, 1, 3);
      add(4'b0000, 0, 4'b0000, 0, 3);

      repeat (2) @(posedge clk);
      #1;
      chk("rst_notify", {31'd0, out_notify}, 32'd0);
      chk("rst_gid", {30'd0, grant_id}, 32'd0);
      chk("rst_data", out_data, 32'd0);
      rst = 1'b0;

      foreach (vt[i]) begin
         req_notify = vt[i].notify;
         out_sync   = vt[i].osync;
         @(negedge clk);
         chk($sformatf("v%0d_sync", i), {28'd0, req_sync}, {28'd0, vt[i].e_sync});
         chk($sformatf("v%0d_notify", i), {31'd0, out_notify}, {31'd0, vt[i].e_onot});
         chk($sformatf("v%0d_gid", i), {30'd0, grant_id}, {30'd0, vt[i].e_gid});
         @(posedge clk);
         #1;
      end

      // async reset mid-send: ptr is 0, requester 1 wins
      req_notify = 4'b0010; out_sync = 1'b0;
      @(posedge clk);
      #1;
      chk("pre_rst_notify", {31'd0, out_notify}, 32'd1);
      chk("pre_rst_gid", {30'd0, grant_id}, 32'd1);
      chk("pre_rst_data", out_data, -32'sd200);
      req_notify = 4'b1111;
      #2 rst = 1'b1;
      #1;
      chk("async_rst_notify", {31'd0, out_notify}, 32'd0);
      chk("async_rst_sync", {28'd0, req_sync}, 32'd0);
      chk("async_rst_gid", {30'd0, grant_id}, 32'd0);
      chk("async_rst_data", out_data, 32'd0);
      @(posedge clk);
      #3 rst = 1'b0;
      req_notify = 4'b0000;
      @(negedge clk);
      chk("post_rst_notify", {31'd0, out_notify}, 32'd0);
      chk("post_rst_gid", {30'd0, grant_id}, 32'd0);
      @(posedge clk);
      #1;
      // rr_ptr restarted at 0
      req_notify = 4'b1111; out_sync = 1'b1;
      @(negedge clk);
      chk("post_rst_ptr", {28'd0, req_sync}, 32'd1);
      @(posedge clk);
      #1;
      req_notify = 4'b0000;
      @(negedge clk);
      chk("post_rst_word", out_data, 32'd100);
      repeat (2) @(posedge clk);
      #1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
